// File: rtl/axi_gearbox_pkg.sv
// axi_gearbox_pkg
// Shared helpers for axi_stream_width_gearbox:
//   beat_bytes  - number of valid bytes carried by an input beat
//   cnt_bits    - width of the byte-count type for a given buffer size
//   buf_ok      - capacity sanity check used at elaboration
package axi_gearbox_pkg;

  localparam int BYTE_W = 8;

  // mod==0 on a final beat means the beat is full width
  function automatic int beat_bytes(int mod, logic eop, int width);
    return (eop && mod != 0) ? mod : width;
  endfunction

  // Byte counts run 0..buf_byts inclusive
  function automatic int cnt_bits(int buf_byts);
    return $clog2(buf_byts + 1);
  endfunction

  // Worst case: one short of a full output beat is stranded when a full
  // input beat must still fit.
  function automatic bit buf_ok(int in_byts, int out_byts, int buf_byts);
    return buf_byts >= in_byts + out_byts - 1;
  endfunction

endpackage

// File: rtl/byte_shift_buf.sv
// byte_shift_buf
// Byte buffer, low byte first. In one cycle it drops i_pop_n bytes from
// the bottom and writes i_push_n bytes of i_push_dat at byte i_push_off
// (offset is already relative to the post-pop contents).
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_pop_n            bytes removed from the bottom this cycle
//   i_push             write enable
//   i_push_off         byte offset of the write (after pop)
//   i_push_n           bytes written
//   i_push_dat         write data, byte 0 in bits [7:0]
//   o_low              lowest OUT_BYTS bytes of the buffer
module byte_shift_buf #(
  parameter int IN_BYTS  = 8,
  parameter int OUT_BYTS = 8,
  parameter int BUF_BYTS = 16,
  parameter int CNT_W    = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [CNT_W-1:0]      i_pop_n,
  input  logic                  i_push,
  input  logic [CNT_W-1:0]      i_push_off,
  input  logic [CNT_W-1:0]      i_push_n,
  input  logic [IN_BYTS*8-1:0]  i_push_dat,
  output logic [OUT_BYTS*8-1:0] o_low
);
  localparam int BW = BUF_BYTS * 8;

  logic [BW-1:0] r_buf;
  logic [BW-1:0] w_shift, w_nmsk, w_pmsk, w_pdat, w_nxt;

  // Bytes at and above the valid count are kept at zero, so the shift only
  // ever pulls zeros into the top.
  always_comb begin
    w_shift = r_buf >> {i_pop_n, 3'b000};
    w_nmsk  = ~({BW{1'b1}} << {i_push_n, 3'b000});
    w_pmsk  = w_nmsk << {i_push_off, 3'b000};
    w_pdat  = BW'(i_push_dat) << {i_push_off, 3'b000};
    w_nxt   = w_shift;
    if (i_push) w_nxt = (w_shift & ~w_pmsk) | (w_pdat & w_pmsk);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_buf <= '0;
    else          r_buf <= w_nxt;
  end

  assign o_low = r_buf[OUT_BYTS*8-1:0];

endmodule

// File: rtl/axi_stream_width_gearbox.sv
// axi_stream_width_gearbox
// Single-clock AXI-stream byte-width converter (any IN/OUT ratio). Packets
// are repacked contiguously and never merged: input stalls from the
// accepted eop until that packet's last output beat has been popped.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_axi_{dat,mod,sop,eop,err,ctl,val}, o_i_axi_rdy   input stream
//   o_axi_{dat,mod,sop,eop,err,ctl,val}, i_o_axi_rdy   output stream
// Optional: define AXI_WIDTH_GEARBOX_PROTO_CHECK_EN to flag input protocol
// violations (nested sop, missing sop, oversize mod) into the packet err.
module axi_stream_width_gearbox
  import axi_gearbox_pkg::*;
#(
  parameter  int IN_DAT_BYTS  = 8,
  parameter  int OUT_DAT_BYTS = 8,
  parameter  int CTL_BITS     = 8,
  parameter  int BUF_BYTS     = IN_DAT_BYTS + OUT_DAT_BYTS,
  localparam int IN_MOD_W     = $clog2(IN_DAT_BYTS + 1),
  localparam int OUT_MOD_W    = $clog2(OUT_DAT_BYTS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [IN_DAT_BYTS*8-1:0]  i_axi_dat,
  input  logic [IN_MOD_W-1:0]       i_axi_mod,
  input  logic                      i_axi_sop,
  input  logic                      i_axi_eop,
  input  logic                      i_axi_err,
  input  logic [CTL_BITS-1:0]       i_axi_ctl,
  input  logic                      i_axi_val,
  output logic                      o_i_axi_rdy,
  output logic [OUT_DAT_BYTS*8-1:0] o_axi_dat,
  output logic [OUT_MOD_W-1:0]      o_axi_mod,
  output logic                      o_axi_sop,
  output logic                      o_axi_eop,
  output logic                      o_axi_err,
  output logic [CTL_BITS-1:0]       o_axi_ctl,
  output logic                      o_axi_val,
  input  logic                      i_o_axi_rdy
);
  localparam int CNT_W = cnt_bits(BUF_BYTS);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t OUT_N = cnt_t'(OUT_DAT_BYTS);

  if (!buf_ok(IN_DAT_BYTS, OUT_DAT_BYTS, BUF_BYTS)) begin : g_buf_chk
    $error("BUF_BYTS must be >= IN_DAT_BYTS+OUT_DAT_BYTS-1");
  end

  cnt_t                r_cnt;
  logic                r_eop_pend, r_first_pend, r_err_l, r_rdy;
  logic [CTL_BITS-1:0] r_ctl_l;

  cnt_t w_in_n, w_pop_n, w_off, w_cnt_nxt;
  logic w_push, w_pop, w_val, w_eop_out, w_eop_pend_nxt, w_rdy_nxt;
  logic w_start, w_viol;
  logic [OUT_DAT_BYTS*8-1:0] w_low, w_vmsk;

  assign w_push    = i_axi_val && r_rdy;
  assign w_val     = (r_cnt >= OUT_N) || (r_eop_pend && r_cnt != '0);
  assign w_eop_out = r_eop_pend && (r_cnt <= OUT_N);
  assign w_pop     = w_val && i_o_axi_rdy;
  assign w_pop_n   = !w_pop ? '0 : (r_cnt < OUT_N) ? r_cnt : OUT_N;
  assign w_off     = r_cnt - w_pop_n;
  assign w_cnt_nxt = w_off + (w_push ? w_in_n : '0);

  // Input stalls on eop, so an eop push never meets an eop pop.
  assign w_eop_pend_nxt = (w_push && i_axi_eop) ||
                          (r_eop_pend && !(w_pop && w_eop_out));
  // Ready is registered: computed from next-cycle count and pend state.
  assign w_rdy_nxt = (int'(w_cnt_nxt) + IN_DAT_BYTS <= BUF_BYTS) && !w_eop_pend_nxt;

`ifdef AXI_WIDTH_GEARBOX_PROTO_CHECK_EN
  logic r_open;
  logic w_mod_bad;

  always_comb begin
    w_mod_bad = i_axi_eop && (int'(i_axi_mod) > IN_DAT_BYTS);
    w_in_n    = cnt_t'(beat_bytes(int'(i_axi_mod), i_axi_eop, IN_DAT_BYTS));
    if (w_mod_bad) w_in_n = cnt_t'(IN_DAT_BYTS);
  end

  // Any beat arriving while idle starts a packet (flagged if it lacks sop);
  // a sop inside an open packet is just more data.
  assign w_start = w_push && !r_open;
  assign w_viol  = w_push && ((i_axi_sop == r_open) || w_mod_bad);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_open <= 1'b0;
    else if (w_push) r_open <= !i_axi_eop;
  end
`else
  assign w_in_n  = cnt_t'(beat_bytes(int'(i_axi_mod), i_axi_eop, IN_DAT_BYTS));
  assign w_start = w_push && i_axi_sop;
  assign w_viol  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_eop_pend   <= 1'b0;
      r_first_pend <= 1'b0;
      r_err_l      <= 1'b0;
      r_ctl_l      <= '0;
      r_rdy        <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_eop_pend <= w_eop_pend_nxt;
      r_rdy      <= w_rdy_nxt;
      if (w_start) r_ctl_l <= i_axi_ctl;
      if (w_start)     r_err_l <= i_axi_err | w_viol;
      else if (w_push) r_err_l <= r_err_l | i_axi_err | w_viol;
      if (w_start)     r_first_pend <= 1'b1;
      else if (w_pop)  r_first_pend <= 1'b0;
    end
  end

  byte_shift_buf #(
    .IN_BYTS (IN_DAT_BYTS),
    .OUT_BYTS(OUT_DAT_BYTS),
    .BUF_BYTS(BUF_BYTS),
    .CNT_W   (CNT_W)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_pop_n   (w_pop_n),
    .i_push    (w_push),
    .i_push_off(w_off),
    .i_push_n  (w_in_n),
    .i_push_dat(i_axi_dat),
    .o_low     (w_low)
  );

  // Zero every output byte at or above the valid count.
  assign w_vmsk = ~({(OUT_DAT_BYTS*8){1'b1}} << {r_cnt, 3'b000});

  assign o_i_axi_rdy = r_rdy;
  assign o_axi_val   = w_val;
  assign o_axi_dat   = w_low & w_vmsk;
  assign o_axi_sop   = r_first_pend;
  assign o_axi_eop   = w_eop_out;
  assign o_axi_mod   = (w_eop_out && r_cnt != OUT_N) ? OUT_MOD_W'(r_cnt) : '0;
  assign o_axi_ctl   = r_ctl_l;
  assign o_axi_err   = r_err_l && w_eop_out;

endmodule

// File: tb/tb_axi_stream_width_gearbox.sv
// Directed bench for axi_stream_width_gearbox: three instances
// (12->8, 8->12, 5->3) driven from one linear stimulus sequence.
module tb_axi_stream_width_gearbox;

`ifdef AXI_WIDTH_GEARBOX_PROTO_CHECK_EN
  localparam bit PROTO = 1'b1;
`else
  localparam bit PROTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // A: 12 -> 8
  logic [95:0] a_idat; logic [3:0] a_imod; logic a_isop, a_ieop, a_ierr, a_ival, a_irdy;
  logic [7:0]  a_ictl;
  logic [63:0] a_odat; logic [3:0] a_omod; logic a_osop, a_oeop, a_oerr, a_oval, a_ordy;
  logic [7:0]  a_octl;
  logic a_hold;
  // B: 8 -> 12
  logic [63:0] b_idat; logic [3:0] b_imod; logic b_isop, b_ieop, b_ierr, b_ival, b_irdy;
  logic [7:0]  b_ictl;
  logic [95:0] b_odat; logic [3:0] b_omod; logic b_osop, b_oeop, b_oerr, b_oval, b_ordy;
  logic [7:0]  b_octl;
  // C: 5 -> 3
  logic [39:0] c_idat; logic [2:0] c_imod; logic c_isop, c_ieop, c_ierr, c_ival, c_irdy;
  logic [7:0]  c_ictl;
  logic [23:0] c_odat; logic [1:0] c_omod; logic c_osop, c_oeop, c_oerr, c_oval, c_ordy;
  logic [7:0]  c_octl;
  logic c_stall;

  assign a_ordy = !a_hold;
  assign b_ordy = 1'b1;
  assign c_ordy = c_stall ? (cyc % 3 == 0) : 1'b1;

  axi_stream_width_gearbox #(.IN_DAT_BYTS(12), .OUT_DAT_BYTS(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_axi_dat(a_idat), .i_axi_mod(a_imod), .i_axi_sop(a_isop), .i_axi_eop(a_ieop),
    .i_axi_err(a_ierr), .i_axi_ctl(a_ictl), .i_axi_val(a_ival), .o_i_axi_rdy(a_irdy),
    .o_axi_dat(a_odat), .o_axi_mod(a_omod), .o_axi_sop(a_osop), .o_axi_eop(a_oeop),
    .o_axi_err(a_oerr), .o_axi_ctl(a_octl), .o_axi_val(a_oval), .i_o_axi_rdy(a_ordy));

  axi_stream_width_gearbox #(.IN_DAT_BYTS(8), .OUT_DAT_BYTS(12)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_axi_dat(b_idat), .i_axi_mod(b_imod), .i_axi_sop(b_isop), .i_axi_eop(b_ieop),
    .i_axi_err(b_ierr), .i_axi_ctl(b_ictl), .i_axi_val(b_ival), .o_i_axi_rdy(b_irdy),
    .o_axi_dat(b_odat), .o_axi_mod(b_omod), .o_axi_sop(b_osop), .o_axi_eop(b_oeop),
    .o_axi_err(b_oerr), .o_axi_ctl(b_octl), .o_axi_val(b_oval), .i_o_axi_rdy(b_ordy));

  axi_stream_width_gearbox #(.IN_DAT_BYTS(5), .OUT_DAT_BYTS(3)) u_c (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_axi_dat(c_idat), .i_axi_mod(c_imod), .i_axi_sop(c_isop), .i_axi_eop(c_ieop),
    .i_axi_err(c_ierr), .i_axi_ctl(c_ictl), .i_axi_val(c_ival), .o_i_axi_rdy(c_irdy),
    .o_axi_dat(c_odat), .o_axi_mod(c_omod), .o_axi_sop(c_osop), .o_axi_eop(c_oeop),
    .o_axi_err(c_oerr), .o_axi_ctl(c_octl), .o_axi_val(c_oval), .i_o_axi_rdy(c_ordy));

  typedef struct {
    logic [95:0] dat;
    int          mod;
    logic        sop, eop, err;
    logic [7:0]  ctl;
  } beat_t;

  beat_t qa[$], qb[$], qc[$];
  beat_t ma, mb, mc;

  // Captured at negedge: the beat that pops on the following posedge.
  always @(negedge clk) begin
    if (a_oval && a_ordy) begin
      ma.dat = 96'(a_odat); ma.mod = int'(a_omod); ma.sop = a_osop;
      ma.eop = a_oeop; ma.err = a_oerr; ma.ctl = a_octl; qa.push_back(ma);
    end
    if (b_oval && b_ordy) begin
      mb.dat = b_odat; mb.mod = int'(b_omod); mb.sop = b_osop;
      mb.eop = b_oeop; mb.err = b_oerr; mb.ctl = b_octl; qb.push_back(mb);
    end
    if (c_oval && c_ordy) begin
      mc.dat = 96'(c_odat); mc.mod = int'(c_omod); mc.sop = c_osop;
      mc.eop = c_oeop; mc.err = c_oerr; mc.ctl = c_octl; qc.push_back(mc);
    end
  end

  // Output of C must hold still while the sink stalls it.
  int          stab_viol = 0;
  logic        c_held = 1'b0;
  logic [23:0] h_dat; logic [1:0] h_mod; logic h_sop, h_eop, h_err; logic [7:0] h_ctl;
  always @(negedge clk) begin
    if (c_held && (!c_oval || c_odat !== h_dat || c_omod !== h_mod || c_osop !== h_sop ||
                   c_oeop !== h_eop || c_oerr !== h_err || c_octl !== h_ctl))
      stab_viol = stab_viol + 1;
    c_held = c_oval && !c_ordy;
    h_dat = c_odat; h_mod = c_omod; h_sop = c_osop; h_eop = c_oeop; h_err = c_oerr; h_ctl = c_octl;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic in_rdy(input int sel);
    case (sel)
      0:       return a_irdy;
      1:       return b_irdy;
      default: return c_irdy;
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [95:0] d, input int m,
                       input logic s, input logic e, input logic er, input logic [7:0] c);
    case (sel)
      0: begin a_ival = v; a_idat = d; a_imod = 4'(m); a_isop = s; a_ieop = e; a_ierr = er; a_ictl = c; end
      1: begin b_ival = v; b_idat = d[63:0]; b_imod = 4'(m); b_isop = s; b_ieop = e; b_ierr = er; b_ictl = c; end
      default: begin c_ival = v; c_idat = d[39:0]; c_imod = 3'(m); c_isop = s; c_ieop = e; c_ierr = er; c_ictl = c; end
    endcase
  endtask

  // Packet bytes are base, base+1, ...; err_beat/sop2_beat pick the beat
  // carrying err or an extra sop (-1 for none).
  task automatic send_pkt(input int sel, input int base, input int len, input logic [7:0] ctl,
                          input int err_beat, input int sop2_beat);
    int inw, nb, m, t;
    logic [95:0] d;
    inw = (sel == 0) ? 12 : (sel == 1) ? 8 : 5;
    nb  = (len + inw - 1) / inw;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int k = 0; k < inw; k++)
        if (b * inw + k < len) d[k*8 +: 8] = 8'(base + b * inw + k);
      m = (b == nb - 1) ? len % inw : 0;
      @(negedge clk);
      drive(sel, 1'b1, d, m, (b == 0) || (b == sop2_beat), b == nb - 1, b == err_beat, ctl);
      t = 0;
      while (!in_rdy(sel) && t < 400) begin @(negedge clk); t++; end
      chk($sformatf("rdy%0d.beat%0d", sel, b), 96'(in_rdy(sel)), 96'(1));
      @(posedge clk);
    end
    @(negedge clk);
    drive(sel, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_beats(input int sel, input int n);
    int t;
    t = 0;
    while (qsize(sel) < n && t < 400) begin @(negedge clk); t++; end
    chk($sformatf("beats%0d", sel), 96'(qsize(sel) >= n), 96'(1));
  endtask

  task automatic check_beat(input int sel, input int idx, input int nbytes, input int first,
                            input logic sop, input logic eop, input int mod, input logic err,
                            input logic [7:0] ctl);
    beat_t bt;
    logic [95:0] e;
    if (idx >= qsize(sel)) return;
    case (sel)
      0:       bt = qa[idx];
      1:       bt = qb[idx];
      default: bt = qc[idx];
    endcase
    e = '0;
    for (int k = 0; k < nbytes; k++) e[k*8 +: 8] = 8'(first + k);
    chk($sformatf("i%0d.b%0d.dat", sel, idx), bt.dat, e);
    chk($sformatf("i%0d.b%0d.sop", sel, idx), 96'(bt.sop), 96'(sop));
    chk($sformatf("i%0d.b%0d.eop", sel, idx), 96'(bt.eop), 96'(eop));
    chk($sformatf("i%0d.b%0d.mod", sel, idx), 96'(bt.mod), 96'(mod));
    chk($sformatf("i%0d.b%0d.err", sel, idx), 96'(bt.err), 96'(err));
    chk($sformatf("i%0d.b%0d.ctl", sel, idx), 96'(bt.ctl), 96'(ctl));
  endtask

  initial begin
    rst_n = 1'b0; a_hold = 1'b0; c_stall = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst.a_irdy", 96'(a_irdy), 96'(0));
    chk("rst.b_irdy", 96'(b_irdy), 96'(0));
    chk("rst.c_irdy", 96'(c_irdy), 96'(0));
    chk("rst.a_oval", 96'(a_oval), 96'(0));
    chk("rst.a_odat", 96'(a_odat), 96'(0));
    chk("rst.c_osop", 96'(c_osop), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.a_irdy", 96'(a_irdy), 96'(1));
    chk("post_rst.b_irdy", 96'(b_irdy), 96'(1));
    chk("post_rst.c_irdy", 96'(c_irdy), 96'(1));

    // 12->8, 28 bytes: 8, 8, 8, then 4 with mod=4
    send_pkt(0, 'h10, 28, 8'hA5, -1, -1);
    wait_beats(0, 4);
    check_beat(0, 0, 8, 'h10, 1, 0, 0, 0, 8'hA5);
    check_beat(0, 1, 8, 'h18, 0, 0, 0, 0, 8'hA5);
    check_beat(0, 2, 8, 'h20, 0, 0, 0, 0, 8'hA5);
    check_beat(0, 3, 4, 'h28, 0, 1, 4, 0, 8'hA5);

    // err on middle input beat shows on eop only, then clears
    send_pkt(0, 'h40, 28, 8'h3C, 1, -1);
    wait_beats(0, 8);
    check_beat(0, 4, 8, 'h40, 1, 0, 0, 0, 8'h3C);
    check_beat(0, 5, 8, 'h48, 0, 0, 0, 0, 8'h3C);
    check_beat(0, 6, 8, 'h50, 0, 0, 0, 0, 8'h3C);
    check_beat(0, 7, 4, 'h58, 0, 1, 4, 1, 8'h3C);
    send_pkt(0, 'h70, 12, 8'h3D, -1, -1);
    wait_beats(0, 10);
    check_beat(0, 8, 8, 'h70, 1, 0, 0, 0, 8'h3D);
    check_beat(0, 9, 4, 'h78, 0, 1, 4, 0, 8'h3D);

    // 8->12, 40 bytes: 12, 12, 12, then 4 with mod=4
    send_pkt(1, 'h80, 40, 8'h5A, -1, -1);
    wait_beats(1, 4);
    check_beat(1, 0, 12, 'h80, 1, 0, 0, 0, 8'h5A);
    check_beat(1, 1, 12, 'h8C, 0, 0, 0, 0, 8'h5A);
    check_beat(1, 2, 12, 'h98, 0, 0, 0, 0, 8'h5A);
    check_beat(1, 3, 4, 'hA4, 0, 1, 4, 0, 8'h5A);

    // 5->3, back-to-back 7-byte packets, sink ready 1 of 3 cycles
    c_stall = 1'b1;
    send_pkt(2, 'hC0, 7, 8'h11, -1, -1);
    send_pkt(2, 'hD0, 7, 8'h22, -1, -1);
    wait_beats(2, 6);
    c_stall = 1'b0;
    check_beat(2, 0, 3, 'hC0, 1, 0, 0, 0, 8'h11);
    check_beat(2, 1, 3, 'hC3, 0, 0, 0, 0, 8'h11);
    check_beat(2, 2, 1, 'hC6, 0, 1, 1, 0, 8'h11);
    check_beat(2, 3, 3, 'hD0, 1, 0, 0, 0, 8'h22);
    check_beat(2, 4, 3, 'hD3, 0, 0, 0, 0, 8'h22);
    check_beat(2, 5, 1, 'hD6, 0, 1, 1, 0, 8'h22);
    chk("c_stall_stable", 96'(stab_viol), 96'(0));

    // Reset with 7 bytes buffered and the sink stalled
    a_hold = 1'b1;
    send_pkt(0, 'h90, 7, 8'hEE, -1, -1);
    @(negedge clk);
    chk("pre_rst.a_oval", 96'(a_oval), 96'(1));
    chk("pre_rst.a_omod", 96'(a_omod), 96'(7));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.a_oval", 96'(a_oval), 96'(0));
    chk("mid_rst.a_odat", 96'(a_odat), 96'(0));
    chk("mid_rst.a_osop", 96'(a_osop), 96'(0));
    chk("mid_rst.a_oeop", 96'(a_oeop), 96'(0));
    chk("mid_rst.a_omod", 96'(a_omod), 96'(0));
    chk("mid_rst.a_oerr", 96'(a_oerr), 96'(0));
    chk("mid_rst.a_octl", 96'(a_octl), 96'(0));
    chk("mid_rst.a_irdy", 96'(a_irdy), 96'(0));
    @(negedge clk);
    rst_n = 1'b1; a_hold = 1'b0;
    @(negedge clk);
    send_pkt(0, 'hB0, 12, 8'h44, -1, -1);
    wait_beats(0, 12);
    check_beat(0, 10, 8, 'hB0, 1, 0, 0, 0, 8'h44);
    check_beat(0, 11, 4, 'hB8, 0, 1, 4, 0, 8'h44);

    // Second sop mid-packet: flagged only with protocol checking built in
    send_pkt(0, 'h60, 28, 8'h77, -1, 1);
    wait_beats(0, 16);
    check_beat(0, 12, 8, 'h60, 1, 0, 0, 0, 8'h77);
    check_beat(0, 13, 8, 'h68, !PROTO, 0, 0, 0, 8'h77);
    check_beat(0, 14, 8, 'h70, 0, 0, 0, 0, 8'h77);
    check_beat(0, 15, 4, 'h78, 0, 1, 4, PROTO, 8'h77);

    // Nothing extra emitted anywhere
    repeat (10) @(negedge clk);
    chk("total_a", 96'(qa.size()), 96'(16));
    chk("total_b", 96'(qb.size()), 96'(4));
    chk("total_c", 96'(qc.size()), 96'(6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
